// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned LINE_NUM_DEF  = 16;
  localparam int unsigned LINE_BITS_DEF = 256;
  localparam int unsigned ADDR_W_DEF    = 32;

  localparam int unsigned OFFSET_W = $clog2(LINE_BITS_DEF / 8);
  localparam int unsigned INDEX_W  = $clog2(LINE_NUM_DEF);
  localparam int unsigned TAG_W    = ADDR_W_DEF - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } dcache_state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: combinational read, synchronous word or full-line write,
// asynchronous clear of valid and dirty.
module dcache_sram #(
  parameter int unsigned LINE_NUM  = 16,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned INDEX_W   = 4,
  parameter int unsigned TAG_W     = 23,
  parameter int unsigned WORD_W    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   index_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 word_we_i,
  input  logic [WORD_W-1:0]    word_i,
  input  logic [31:0]          word_data_i,
  input  logic                 line_we_i,
  input  logic [TAG_W-1:0]     line_tag_i,
  input  logic [LINE_BITS-1:0] line_data_i
);

  localparam int unsigned Words = LINE_BITS / 32;

  logic [Words-1:0][31:0] data_q [LINE_NUM];
  logic [TAG_W-1:0]       tag_q  [LINE_NUM];
  logic [LINE_NUM-1:0]    valid_q, dirty_q;

  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign line_o  = data_q[index_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates every use.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[index_i] <= line_data_i;
      tag_q[index_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_q[index_i][word_i] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with zero-latency hits.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_NUM  = LINE_NUM_DEF,
  parameter int unsigned LINE_BITS = LINE_BITS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int unsigned OffsetW = $clog2(LINE_BITS / 8);
  localparam int unsigned IndexW  = $clog2(LINE_NUM);
  localparam int unsigned TagW    = ADDR_W - IndexW - OffsetW;
  localparam int unsigned WordW   = OffsetW - 2;

  dcache_state_t          state_q;
  logic                   mem_enable_q, mem_write_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [LINE_BITS-1:0]   refill_q;

  logic [TagW-1:0]        req_tag, rd_tag;
  logic [IndexW-1:0]      req_index;
  logic [WordW-1:0]       req_word;
  logic                   rd_valid, rd_dirty, lookup_hit, idle_hit, miss;
  logic [LINE_BITS/32-1:0][31:0] rd_line;
  logic                   unused_addr;

  assign req_tag     = cpu_addr_i[ADDR_W-1 -: TagW];
  assign req_index   = cpu_addr_i[OffsetW +: IndexW];
  assign req_word    = cpu_addr_i[OffsetW-1:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign lookup_hit = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign idle_hit   = (state_q == IDLE) & lookup_hit;
  assign miss       = (state_q == IDLE) & cpu_req_i & ~lookup_hit;

  dcache_sram #(
    .LINE_NUM  (LINE_NUM),
    .LINE_BITS (LINE_BITS),
    .INDEX_W   (IndexW),
    .TAG_W     (TagW),
    .WORD_W    (WordW)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .index_i     (req_index),
    .tag_o       (rd_tag),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .line_o      (rd_line),
    .word_we_i   (idle_hit & cpu_we_i),
    .word_i      (req_word),
    .word_data_i (cpu_data_i),
    .line_we_i   (state_q == UPDATE),
    .line_tag_i  (req_tag),
    .line_data_i (refill_q)
  );

  // Reset forces the pipeline-facing outputs quiet even while a request is held.
  assign cpu_stall_o  = rst_i & ((state_q != IDLE) | miss);
  assign cpu_data_o   = (rst_i && idle_hit && !cpu_we_i) ? rd_line[req_word] : 32'd0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = rd_line;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      refill_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            mem_enable_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {rd_tag, req_index, OffsetW'(0)};
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_index, OffsetW'(0)};
            end
          end
        end
        WRITEBACK: begin
          // Enable stays high straight into the refill request.
          if (mem_ack_i) begin
            state_q     <= REFILL;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_tag, req_index, OffsetW'(0)};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state_q      <= UPDATE;
            mem_enable_q <= 1'b0;
            refill_q     <= mem_data_i;
          end
        end
        UPDATE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The lookup right after UPDATE is the replay of an already counted miss.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      retry_q <= (state_q == UPDATE);
      if (idle_hit && !retry_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench: flat golden memory plus a line-level cache model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Golden program-order memory and the external memory's backing store, by word address.
  logic [31:0] gmem [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];
  bit          mvalid [16];
  bit          mdirty [16];
  logic [22:0] mtag   [16];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : init_word(a);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] back_line(input logic [31:0] la);
    logic [255:0] l;
    logic [31:0]  a;
    for (int w = 0; w < 8; w++) begin
      a = la + 32'(w * 4);
      l[w*32 +: 32] = bmem.exists(a) ? bmem[a] : init_word(a);
    end
    return l;
  endfunction

  task automatic store_line(input logic [31:0] la, input logic [255:0] l);
    for (int w = 0; w < 8; w++) bmem[la + 32'(w * 4)] = l[w*32 +: 32];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    gmem = bmem;  // dirty data held only in the cache is lost
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lwb, input int lrf);
    int          idx, exp_stall, stalls, cnt, n_wb;
    logic [22:0] tg;
    bit          hit, wb, done;
    logic [31:0] wb_addr;
    logic [255:0] wb_line;
    idx       = int'(addr[8:5]);
    tg        = addr[31:9];
    hit       = mvalid[idx] && (mtag[idx] == tg);
    wb        = !hit && mvalid[idx] && mdirty[idx];
    wb_addr   = {mtag[idx], addr[8:5], 5'd0};
    wb_line   = gold_line(wb_addr);
    exp_stall = hit ? 0 : (wb ? lwb + lrf + 2 : lrf + 2);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    #1;
    stalls = 0; cnt = 0; n_wb = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (!cpu_stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (mem_enable_o) begin
          if (cnt == 0) begin
            if (mem_write_o) begin
              n_wb++;
              check("wb_addr", mem_addr_o, wb_addr);
              check("wb_data", mem_data_o, wb_line);
            end else begin
              check("rf_addr", mem_addr_o, {addr[31:5], 5'd0});
            end
          end
          cnt++;
          if (cnt == (mem_write_o ? lwb : lrf)) begin
            mem_ack_i = 1'b1;
            if (mem_write_o) store_line(mem_addr_o, mem_data_o);
            else mem_data_i = back_line(mem_addr_o);
            cnt = 0;
          end
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        @(negedge clk_i); #1;
      end
    end
    check("stall_done", done, 1'b1);
    check("stall_cycles", stalls, exp_stall);
    check("wb_count", n_wb, wb ? 1 : 0);
    if (hit) check("hit_mem_idle", mem_enable_o, 1'b0);
    if (!we) check("load_data", cpu_data_o, gold_rd(addr));
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    if (!hit) begin
      mvalid[idx] = 1'b1; mtag[idx] = tg; mdirty[idx] = 1'b0;
    end
    if (we) begin
      mdirty[idx] = 1'b1;
      gmem[addr] = wdata;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    #1;
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_data", cpu_data_o, 32'd0);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] a;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    bmem[32'h40] = 32'h11;
    gmem[32'h40] = 32'h11;
    model_reset();
    repeat (2) @(posedge clk_i);
    apply_reset();

    do_access(1'b0, 32'h40, 32'h0, 1, 10);           // cold load, L=10
    do_access(1'b1, 32'h44, 32'hAB, 1, 1);           // store hit
    do_access(1'b0, 32'h44, 32'h0, 1, 1);            // load hit
    do_access(1'b0, 32'h240, 32'h0, 3, 4);           // dirty victim write-back then refill
    do_access(1'b0, 32'h1000, 32'h0, 1, 1);          // ack with enable rise

    // Reset in the middle of a refill.
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    repeat (3) @(negedge clk_i);
    #1;
    check("mid_rf_enable", mem_enable_o, 1'b1);
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    check("mid_rst_stall", cpu_stall_o, 1'b0);
    check("mid_rst_enable", mem_enable_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    do_access(1'b0, 32'h80, 32'h0, 2, 5);
    do_access(1'b0, 32'h40, 32'h0, 2, 2);

    for (int i = 0; i < 200; i++) begin
      a = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4),
                $urandom_range(1, 4));
    end

`ifdef DCACHE_STATS_EN
    apply_reset();
    check("hit_cnt_rst", hit_cnt_o, 32'd0);
    do_access(1'b0, 32'h40, 32'h0, 1, 10);
    do_access(1'b1, 32'h44, 32'hAB, 1, 1);
    do_access(1'b0, 32'h44, 32'h0, 1, 1);
    check("hit_cnt", hit_cnt_o, 32'd2);
    check("miss_cnt", miss_cnt_o, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
